// File: rtl/mem_port_arbiter.sv
// Two-master (fetch/data) arbiter onto one pipelined memory port with in-order response routing.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_unexp_o
);

  localparam int AW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_mo
    $error("MAX_OUTSTANDING out of range");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_sl
    $error("STARVE_LIMIT out of range");
  end

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

  arb_state_e r_state;
  logic       r_owner;
  logic       r_err_unexp;
  logic [2:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [MAX_OUTSTANDING-1:0] r_fifo;

  logic w_force_instr;
  logic w_win_data;
  logic w_sel;
  logic w_sel_req;
  logic w_push;
  logic w_pop;
  logic w_head;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_starve;

  assign w_force_instr = instr_req_i &&
                         (r_starve >= 4'(STARVE_LIMIT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= 4'd0;
    end else if (!instr_req_i || instr_gnt_o) begin
      r_starve <= 4'd0;
    end else if (data_gnt_o && r_starve != 4'hF) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_force_instr = 1'b0;
`endif

  assign w_win_data = data_req_i && !w_force_instr;
  assign w_sel      = (r_state == ARB_HOLD) ? r_owner : w_win_data;
  assign w_sel_req  = w_sel ? data_req_i : instr_req_i;

  // Saturated count blocks even when a pop lands this cycle.
  assign mem_req_o   = w_sel_req &&
                       (r_count < 3'(MAX_OUTSTANDING));
  assign mem_we_o    = w_sel ? data_we_i    : 1'b0;
  assign mem_be_o    = w_sel ? data_be_i    : 4'b1111;
  assign mem_addr_o  = w_sel ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = w_sel ? data_wdata_i : 32'd0;

  assign w_push      = mem_gnt_i && mem_req_o;
  assign instr_gnt_o = w_push && !w_sel;
  assign data_gnt_o  = w_push &&  w_sel;

  assign w_pop  = mem_rvalid_i && (r_count != 3'd0);
  assign w_head = r_fifo[r_rd_ptr];

  assign instr_rvalid_o = w_pop && !w_head;
  assign data_rvalid_o  = w_pop &&  w_head;
  assign instr_err_o    = w_pop && !w_head && mem_err_i;
  assign data_err_o     = w_pop &&  w_head && mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign err_unexp_o    = r_err_unexp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_owner <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (mem_req_o && !mem_gnt_i) begin
            r_owner <= w_sel;
            r_state <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (mem_gnt_i || !w_sel_req) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fifo      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= 3'd0;
      r_err_unexp <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr         <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 3'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 3'd1;
      end
      if (mem_rvalid_i && r_count == 3'd0) begin
        r_err_unexp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter.
// Starvation sequence follows ARB_STARVE_GUARD_EN when defined.
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;
  logic        err_unexp_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_q[$];

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
    .mem_rdata_i(mem_rdata_i), .err_unexp_o(err_unexp_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    instr_req_i  = 1'b0;
    instr_addr_i = 32'd0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'd0;
    data_addr_i  = 32'd0;
    data_wdata_i = 32'd0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = 32'd0;
  endtask

  // Drive one response and check its routing against the scoreboard.
  task automatic resp(input logic [31:0] rd, input logic er);
    bit s;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    mem_err_i    = er;
    #1;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      chk("instr_rvalid", {31'd0, instr_rvalid_o}, {31'd0, !s});
      chk("data_rvalid", {31'd0, data_rvalid_o}, {31'd0, s});
      chk("instr_err", {31'd0, instr_err_o}, {31'd0, !s && er});
      chk("data_err", {31'd0, data_err_o}, {31'd0, s && er});
      chk("rdata", s ? data_rdata_o : instr_rdata_o, rd);
    end else begin
      chk("no_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    end
  endtask

  initial begin
    int st;
    bit exp_i;
    idle_in();
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_err_unexp", {31'd0, err_unexp_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
    chk("rst_rvalids", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Both request, immediate grant: data wins.
    @(negedge clk_i);
    instr_req_i = 1'b1; instr_addr_i = 32'h1000;
    data_req_i = 1'b1; data_addr_i = 32'h2000;
    data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'hDEAD;
    mem_gnt_i = 1'b1;
    #1;
    chk("A_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    chk("A_instr_gnt", {31'd0, instr_gnt_o}, 32'd0);
    chk("A_addr", mem_addr_o, 32'h2000);
    chk("A_we", {31'd0, mem_we_o}, 32'd1);
    chk("A_be", {28'd0, mem_be_o}, 32'h3);
    chk("A_wdata", mem_wdata_o, 32'hDEAD);
    exp_q.push_back(1'b1);
    @(negedge clk_i);
    idle_in();
    resp(32'h1111_2222, 1'b0);

    // Fetch held through three ungranted cycles while data rises.
    @(negedge clk_i);
    idle_in();
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    #1;
    chk("B_req", {31'd0, mem_req_o}, 32'd1);
    chk("B_addr0", mem_addr_o, 32'h100);
    chk("B_be", {28'd0, mem_be_o}, 32'hF);
    chk("B_we", {31'd0, mem_we_o}, 32'd0);
    chk("B_wdata", mem_wdata_o, 32'd0);
    chk("B_gnt0", {31'd0, instr_gnt_o}, 32'd0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk_i);
      data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b1;
      #1;
      chk("B_hold_addr", mem_addr_o, 32'h100);
      chk("B_hold_we", {31'd0, mem_we_o}, 32'd0);
      chk("B_hold_dgnt", {31'd0, data_gnt_o}, 32'd0);
    end
    @(negedge clk_i);
    mem_gnt_i = 1'b1;
    #1;
    chk("B_igrant", {31'd0, instr_gnt_o}, 32'd1);
    chk("B_dgrant", {31'd0, data_gnt_o}, 32'd0);
    chk("B_addr3", mem_addr_o, 32'h100);
    exp_q.push_back(1'b0);
    @(negedge clk_i);
    instr_req_i = 1'b0; mem_gnt_i = 1'b0;
    resp(32'h0000_00A1, 1'b1);
    chk("B_data_sel", mem_addr_o, 32'h200);
    chk("B_data_req", {31'd0, mem_req_o}, 32'd1);
    @(negedge clk_i);
    idle_in();
    #1;
    chk("B_drop_req", {31'd0, mem_req_o}, 32'd0);

    // Outstanding limit: saturation blocks even with a same-cycle pop.
    @(negedge clk_i);
    data_req_i = 1'b1; data_addr_i = 32'h300; mem_gnt_i = 1'b1;
    #1;
    chk("C_g1", {31'd0, data_gnt_o}, 32'd1);
    exp_q.push_back(1'b1);
    @(negedge clk_i);
    #1;
    chk("C_g2", {31'd0, data_gnt_o}, 32'd1);
    exp_q.push_back(1'b1);
    @(negedge clk_i);
    resp(32'h0000_00C0, 1'b0);
    chk("C_sat_req", {31'd0, mem_req_o}, 32'd0);
    chk("C_sat_gnt", {31'd0, data_gnt_o}, 32'd0);
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    #1;
    chk("C_req_back", {31'd0, mem_req_o}, 32'd1);
    chk("C_g3", {31'd0, data_gnt_o}, 32'd1);
    exp_q.push_back(1'b1);
    @(negedge clk_i);
    idle_in();
    resp(32'h0000_00C1, 1'b0);
    @(negedge clk_i);
    idle_in();
    resp(32'h0000_00C2, 1'b0);

    // Instr then data grants, responses 2 and 3 cycles later.
    @(negedge clk_i);
    idle_in();
    instr_req_i = 1'b1; instr_addr_i = 32'h400; mem_gnt_i = 1'b1;
    #1;
    chk("D_igrant", {31'd0, instr_gnt_o}, 32'd1);
    exp_q.push_back(1'b0);
    @(negedge clk_i);
    idle_in();
    data_req_i = 1'b1; data_addr_i = 32'h500; mem_gnt_i = 1'b1;
    #1;
    chk("D_dgrant", {31'd0, data_gnt_o}, 32'd1);
    exp_q.push_back(1'b1);
    @(negedge clk_i);
    idle_in();
    #1;
    chk("D_gap", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    @(negedge clk_i);
    idle_in();
    resp(32'hA5A5_A5A5, 1'b0);
    @(negedge clk_i);
    idle_in();
    resp(32'h1234_5678, 1'b0);

    // Continuous contention with a response every cycle.
    st = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      idle_in();
      instr_req_i = 1'b1; instr_addr_i = 32'h600;
      data_req_i = 1'b1; data_addr_i = 32'h700;
      mem_gnt_i = 1'b1;
      if (k > 0) resp(32'hE0 + k, 1'b0);
      else #1;
      exp_i = GUARD && (st >= 4);
      chk("E_instr_gnt", {31'd0, instr_gnt_o}, {31'd0, exp_i});
      chk("E_data_gnt", {31'd0, data_gnt_o}, {31'd0, !exp_i});
      exp_q.push_back(!exp_i);
      if (exp_i) st = 0;
      else if (st < 15) st = st + 1;
    end
    @(negedge clk_i);
    idle_in();
    resp(32'h0000_00EF, 1'b0);

    // Unexpected response with nothing outstanding.
    @(negedge clk_i);
    idle_in();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD;
    #1;
    chk("F_no_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    @(negedge clk_i);
    idle_in();
    #1;
    chk("F_unexp_set", {31'd0, err_unexp_o}, 32'd1);
    repeat (3) @(negedge clk_i);
    #1;
    chk("F_unexp_sticky", {31'd0, err_unexp_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("F_unexp_rst", {31'd0, err_unexp_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset discards an outstanding grant.
    @(negedge clk_i);
    data_req_i = 1'b1; mem_gnt_i = 1'b1;
    #1;
    chk("G_grant", {31'd0, data_gnt_o}, 32'd1);
    @(negedge clk_i);
    idle_in();
    rst_ni = 1'b0;
    #1;
    chk("G_rst_err", {31'd0, err_unexp_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1;
    #1;
    chk("G_no_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    @(negedge clk_i);
    idle_in();
    #1;
    chk("G_unexp", {31'd0, err_unexp_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, 2: owner-FIFO depth (1..4); maximum granted transactions awaiting rvalid.
REQ-002 Parameter STARVE_LIMIT, 4: consecutive data wins allowed while instr is waiting (1..15).
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 instr_req_i / instr_addr_i  input  1/32  fetch request and word address.
REQ-006 instr_gnt_o / instr_rvalid_o / instr_err_o  output  1/1/1  fetch grant, response valid, bus error.
REQ-007 instr_rdata_o  output  32  fetch read data.
REQ-008 data_req_i / data_we_i / data_be_i / data_addr_i / data_wdata_i  input  1/1/4/32/32  load/store request.
REQ-009 data_gnt_o / data_rvalid_o / data_err_o  output  1/1/1  data grant, response valid, bus error.
REQ-010 data_rdata_o  output  32  load read data.
REQ-011 mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  output  1/1/4/32/32  shared memory port request.
REQ-012 mem_gnt_i / mem_rvalid_i / mem_err_i  input  1/1/1  shared port grant, response valid, error.
REQ-013 mem_rdata_i  input  32  shared port read data.
REQ-014 err_unexp_o  output  1  sticky flag: mem_rvalid_i seen with no outstanding transaction.

Function
REQ-015 State machine with two states, ARB_IDLE and ARB_HOLD, plus a registered owner bit (0=instr, 1=data).
REQ-016 ARB_IDLE: winner is chosen combinationally; data wins over instr unless the starve guard (REQ-025) forces instr; the single requester wins when only one requests.
REQ-017 mem_req_o = winner's req AND (outstanding count < MAX_OUTSTANDING); count saturated blocks new requests even if a pop occurs that cycle.
REQ-018 mem_we_o/be_o/addr_o/wdata_o drive the selected owner's fields; instr side drives we=0, be=4'b1111, wdata=0.
REQ-019 ARB_IDLE with mem_req_o=1 and mem_gnt_i=0: latch winner into owner, go ARB_HOLD.
REQ-020 ARB_HOLD: selection frozen to owner regardless of other requests; mem_gnt_i=1 returns to ARB_IDLE; owner deasserting its req returns to ARB_IDLE with no push.
REQ-021 Grant: instr_gnt_o/data_gnt_o = mem_gnt_i AND mem_req_o AND selected side; zero-cycle pass-through, never both high.
REQ-022 Each grant pushes the owner id into the owner FIFO; each mem_rvalid_i pops the head; simultaneous push and pop keep count constant.
REQ-023 mem_rvalid_i routed to instr_rvalid_o or data_rvalid_o per FIFO head, same cycle; mem_err_i routed likewise; mem_rdata_i drives both rdata outputs unconditionally.
REQ-024 mem_rvalid_i with empty FIFO: no rvalid output, no pop, err_unexp_o set until reset.
REQ-025 Starve counter (4 bits): increments on each data grant while instr_req_i=1; clears on instr grant or when instr_req_i=0; at STARVE_LIMIT instr wins in ARB_IDLE.
REQ-026 First response may arrive no earlier than the cycle after its grant; responses return in grant order.

Reset
REQ-027 rst_ni low: state ARB_IDLE, owner 0, FIFO empty, count 0, starve counter 0, err_unexp_o 0; all registered outputs 0 immediately.
REQ-028 Reset mid-transaction discards outstanding entries; any later rvalid for them sets err_unexp_o.

Configuration
REQ-029 Macro ARB_STARVE_GUARD_EN defined: REQ-025 starve counter is present and active.
REQ-030 Macro undefined: counter omitted, strict data-over-instr priority, STARVE_LIMIT ignored.

Verification
REQ-031 Both req high, mem_gnt_i=1, count 0 -> data_gnt_o=1, instr_gnt_o=0, mem_addr_o=data_addr_i, FIFO head=data.
REQ-032 instr_req_i alone, mem_gnt_i low 3 cycles, data_req_i rises cycle 1 -> stays ARB_HOLD on instr, mem_addr_o=instr_addr_i until grant cycle 3.
REQ-033 MAX_OUTSTANDING=2, two grants without rvalid -> mem_req_o=0 on third request; one mem_rvalid_i -> mem_req_o=1 next cycle.
REQ-034 Grants instr then data, rvalids 2 and 3 cycles later with rdata 0xA5A5A5A5, 0x12345678 -> instr_rvalid_o then data_rvalid_o with matching rdata.
REQ-035 ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, both req held, gnt every cycle -> grants D,D,D,D,I,D...; without macro -> data granted every cycle.
REQ-036 mem_rvalid_i pulse with FIFO empty -> no rvalid outputs, err_unexp_o=1 until rst_ni low.
